// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, line levels, receiver state encoding.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Used by the RX deserializer, the TX serializer and the FIFO controller so all
// three agree on frame geometry and idle/start line levels.
package uart_pkg;

  // Frame geometry defaults.
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_BIT_CNT_W  = 3;

  // Serial line levels.
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Receiver framing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_rx_state_t;

  // Parity bit a transmitter would append to 'data'.
  // Even parity: bit makes the total number of ones even; odd: makes it odd.
  // Narrower words are zero-extended by the caller, which leaves parity unchanged.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input, resetting to line idle (1).
// Latency: 2 clk from input change to o_q.
// Backpressure: none, free running.
//
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (flops go to 1)
//   i_d   - asynchronous input
//   o_q   - synchronised output
module sync_2ff
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= UART_IDLE_LEVEL;
      r_sync <= UART_IDLE_LEVEL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: oversampled framing of start/data/parity/stop into bytes.
// Latency: strobes one clk after the baud_tick that samples the stop bit.
// Backpressure: none; a good byte arriving while fifofull=1 is dropped with overrun_err.
//
// Ports:
//   clk, rst_n             - system clock, asynchronous active-low reset
//   baud_tick              - one-clk enable at OVERSAMPLE x baud rate
//   rx_serial              - asynchronous serial line, idle high
//   parity_en, parity_odd  - frame parity configuration, captured at start of frame
//   fifofull               - downstream FIFO full
//   rx_data                - last received byte, held until the next frame completes
//   rx_wr                  - one-clk write strobe for a good byte
//   rx_done                - one-clk pulse at the end of every frame
//   frame_err/parity_err/overrun_err - one-clk error pulses, coincident with rx_done
//   busy                   - receiver not idle
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 fifofull,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_wr,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST = UART_BIT_CNT_W'(DATA_BITS - 1);

  // Synchronised serial line; the raw input is never used directly.
  logic w_rxs;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_serial),
    .o_q   (w_rxs)
  );

  // State and counters.
  uart_rx_state_t              r_state;
  uart_rx_state_t              w_state_nxt;
  logic [TW-1:0]               r_tick_cnt;
  logic [UART_BIT_CNT_W-1:0]   r_bit_cnt;

  // Frame datapath.
  logic [DATA_BITS-1:0]        r_shift;
  logic                        r_par_bit;
  logic                        r_par_en;
  logic                        r_par_odd;

  // Registered outputs.
  logic [DATA_BITS-1:0]        r_rx_data;
  logic                        r_rx_wr;
  logic                        r_rx_done;
  logic                        r_frame_err;
  logic                        r_parity_err;
  logic                        r_overrun_err;

  // Next-cycle strobes and datapath enables from the FSM.
  logic w_done_nxt;
  logic w_wr_nxt;
  logic w_ferr_nxt;
  logic w_perr_nxt;
  logic w_oerr_nxt;
  logic w_shift_en;
  logic w_par_smp;
  logic w_latch_cfg;

  logic w_tick_mid;
  logic w_tick_end;
  logic w_par_bad;
  logic w_state_chg;

  assign w_tick_mid  = baud_tick && (r_tick_cnt == TICK_MID);
  assign w_tick_end  = baud_tick && (r_tick_cnt == TICK_END);
  assign w_state_chg = (w_state_nxt != r_state);

  // Parity configuration is the copy captured at start of frame, so a mid-frame
  // change of parity_en/parity_odd cannot corrupt the frame in flight.
  assign w_par_bad = r_par_en &&
                     (r_par_bit != uart_parity(8'(r_shift), r_par_odd));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle actions.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_wr_nxt    = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;
    w_oerr_nxt  = 1'b0;
    w_shift_en  = 1'b0;
    w_par_smp   = 1'b0;
    w_latch_cfg = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (baud_tick && (w_rxs == UART_START_LEVEL)) begin
          w_state_nxt = ST_START;
          w_latch_cfg = 1'b1;
        end
      end

      // Re-check the line half a bit in: a high level means the falling edge
      // was noise, not a start bit.
      ST_START: begin
        if (w_tick_mid) begin
          w_state_nxt = (w_rxs == UART_IDLE_LEVEL) ? ST_IDLE : ST_DATA;
        end
      end

      // tick_cnt is aligned to mid-bit after START, so the wrap point samples
      // each data bit at its centre.
      ST_DATA: begin
        if (w_tick_end) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        if (w_tick_end) begin
          w_par_smp   = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end

      // Leaving mid stop bit lets a start edge at the nominal stop-bit end be
      // caught for back-to-back frames. Frame error outranks parity error, which
      // outranks overrun.
      ST_STOP: begin
        if (w_tick_end) begin
          w_done_nxt = 1'b1;
          if (w_rxs != UART_IDLE_LEVEL) begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = ST_BREAK;
          end else if (w_par_bad) begin
            w_perr_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (fifofull) begin
            w_oerr_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_wr_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      // A held-low line must rise before another start bit is accepted.
      ST_BREAK: begin
        if (baud_tick && (w_rxs == UART_IDLE_LEVEL)) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Oversample and bit counters; both restart on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_state_chg) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (baud_tick) begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
      if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + UART_BIT_CNT_W'(1);
      end
    end
  end

  // Frame datapath: shift in LSB first, capture parity bit and configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
    end else begin
      if (w_latch_cfg) begin
        r_par_en  <= parity_en;
        r_par_odd <= parity_odd;
      end
      if (w_shift_en) begin
        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      end
      if (w_par_smp) begin
        r_par_bit <= w_rxs;
      end
    end
  end

  // Output registers; rx_data is updated for every completed frame, good or bad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data     <= '0;
      r_rx_wr       <= 1'b0;
      r_rx_done     <= 1'b0;
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_done_nxt) begin
        r_rx_data <= r_shift;
      end
      r_rx_wr       <= w_wr_nxt;
      r_rx_done     <= w_done_nxt;
      r_frame_err   <= w_ferr_nxt;
      r_parity_err  <= w_perr_nxt;
      r_overrun_err <= w_oerr_nxt;
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_wr       = r_rx_wr;
  assign rx_done     = r_rx_done;
  assign frame_err   = r_frame_err;
  assign parity_err  = r_parity_err;
  assign overrun_err = r_overrun_err;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receive front end. Oversamples the serial line, frames start/data/optional parity/stop bits, and delivers each good byte with a one-cycle write strobe.
- Sits directly upstream of the receive FIFO controller: rx_wr drives its fifowr, rx_done drives its RXdone, and rx_data feeds the RX memory write port.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period (power of two, ≥8).
- DATA_BITS, 8, data bits per frame (5..8), LSB first.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- baud_tick  input  1  one-clk enable pulse at OVERSAMPLE × baud rate
- rx_serial  input  1  asynchronous serial line, idle high
- parity_en  input  1  1 = frame carries a parity bit
- parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en=0
- fifofull  input  1  downstream FIFO full
- rx_data  output  DATA_BITS  last received byte, held until the next frame completes
- rx_wr  output  1  one-clk write strobe for a good byte
- rx_done  output  1  one-clk pulse at the end of every frame, good or bad
- frame_err  output  1  one-clk pulse: stop bit sampled 0
- parity_err  output  1  one-clk pulse: parity mismatch
- overrun_err  output  1  one-clk pulse: good byte dropped because fifofull=1
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset values: rx_data=0, all strobes=0, busy=0, state=IDLE. Synchroniser flops reset to 1 (line idle). Reset mid-frame aborts the frame with no strobes.
- rx_serial passes through a 2-FF synchroniser; only the synchronised value (rxs) is used. Counters advance only on clocks where baud_tick=1.
- tick_cnt width is log2(OVERSAMPLE); bit_cnt width is 3. Both clear on every state entry.
- IDLE: on a baud_tick with rxs=0, go to START.
- START: at tick_cnt=OVERSAMPLE/2-1 (mid start bit), if rxs=1 treat it as a glitch and return to IDLE with no strobes; otherwise go to DATA.
- DATA: sample at each tick_cnt=OVERSAMPLE-1 and shift right into the MSB of the shift register, so bits land LSB first. After DATA_BITS samples, go to PARITY if parity_en, else to STOP.
- PARITY: sample at tick_cnt=OVERSAMPLE-1. Error when the XOR of data bits and the parity bit, XORed with parity_odd, is 1.
- STOP: sample at tick_cnt=OVERSAMPLE-1. On the following clk:
  - rx_done=1.
  - rx_data is updated with the frame's byte.
  - stop=0: frame_err=1, rx_wr=0, go to BREAK.
  - stop=1 and parity error: parity_err=1, rx_wr=0, go to IDLE.
  - stop=1, parity ok, fifofull=0: rx_wr=1, go to IDLE.
  - stop=1, parity ok, fifofull=1: overrun_err=1, rx_wr=0, go to IDLE.
- BREAK: wait for rxs=1 on a baud_tick, then go to IDLE. A held-low line never produces repeated frames.
- parity_en and parity_odd are sampled at START entry and held for the frame.
- Latency: strobes appear exactly one clk after the baud_tick that samples the stop bit.
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge arriving at the nominal stop-bit end is caught.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum {IDLE, START, DATA, PARITY, STOP, BREAK}
  - the OVERSAMPLE and DATA_BITS defaults
  - constants shared with the TX side and the FIFO controller
- One sub-module, sync_2ff: a reset-to-1 two-flop synchroniser, reused for the CTS input later.

Test Plan:
- 8N1 frame 0x55 at 16× ticks, fifofull=0 -> rx_data=0x55, one rx_wr and one rx_done in the same clk, no error pulses, busy falls the next clk.
- Start glitch held low for 4 ticks, then high -> return to IDLE at tick 8, no rx_done, rx_data unchanged.
- Even parity enabled, byte 0x03 sent with parity bit 1 -> parity_err=1, rx_done=1, rx_wr=0, rx_data=0x03.
- Stop bit 0 with the line held low for 3 bit times -> single frame_err and single rx_done, state stays BREAK until the line rises, then the next 0xA5 frame is received correctly.
- Good byte 0x3C with fifofull=1 -> overrun_err=1, rx_wr=0, rx_done=1. A second frame 0x3D with fifofull=0 -> rx_wr=1.
- rst_n pulsed low during bit 4 of a frame -> all outputs reset immediately, no strobes. The next full frame 0x81 is received cleanly.
